// File: rtl/cpu_types_pkg.sv
// Shared cache types: dcache address fields and snoop FSM states.
// Imported by the snoop responder and its tag-match helper.
package cpu_types_pkg;

  localparam int TAG_W = 26;
  localparam int IDX_W = 3;
  localparam int BLK_W = 1;
  localparam int BYT_W = 2;
  localparam int WAYS  = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [BLK_W-1:0] blkoff;
    logic [BYT_W-1:0] bytoff;
  } dcachef_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAN,
    SEND0,
    SEND1
  } snoop_state_t;

endpackage

// File: rtl/dcache_snoop_responder_if.sv
// Snoop handshake between coherence controller and one L1 dcache.
// master: controller drives ccwait/ccinv/addr/dwait; slave: cache answers.
interface dcache_snoop_responder_if;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dwait;
  logic        ccwrite;
  logic [31:0] dstore;
  logic [31:0] daddr;
  logic        snoop_busy;

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    input  ccwrite, dstore, daddr, snoop_busy
  );

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    output ccwrite, dstore, daddr, snoop_busy
  );
endinterface

// File: rtl/dcache_snoop_responder_tag_match.sv
// Combinational 2-way tag compare for the snooped set.
// Ports: per-way valid/dirty/tag in, snooped tag in; hit/way/dirty out.
module snoop_tag_match
  import cpu_types_pkg::*;
(
  input  logic [1:0]            valid_i,
  input  logic [1:0]            dirty_i,
  input  logic [1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]      snp_tag_i,
  output logic                  hit_o,
  output logic                  hit_way_o,
  output logic                  hit_dirty_o
);
  logic m0, m1;

  assign m0 = valid_i[0] && (tag_i[0] == snp_tag_i);
  assign m1 = valid_i[1] && (tag_i[1] == snp_tag_i);

  // Way 0 wins if a corrupted frame ever matches twice.
  assign hit_o       = m0 | m1;
  assign hit_way_o   = !m0 && m1;
  assign hit_dirty_o = m0 ? dirty_i[0] : (m1 && dirty_i[1]);
endmodule

// File: rtl/dcache_snoop_responder.sv
// Snoop responder: looks up snooped block, supplies dirty data, downgrades.
// Ports: CLK/RST, cc (snoop handshake), frame_* (set lookup + update strobe).
module dcache_snoop_responder
  import cpu_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  dcache_snoop_responder_if.slave cc,
  input  logic [1:0]            frame_valid,
  input  logic [1:0]            frame_dirty,
  input  logic [1:0][TAG_W-1:0] frame_tag,
  input  logic [1:0][31:0]      frame_word0,
  input  logic [1:0][31:0]      frame_word1,
  output logic [IDX_W-1:0]      frame_index,
  output logic                  frame_we,
  output logic                  frame_way,
  output logic                  frame_valid_next,
  output logic                  frame_dirty_next
);
  snoop_state_t state_q;
  logic [28:0]  blk_q;
  logic         way_q;
  logic         hit_q;
  logic         inv_q;

  dcachef_t snp;
  logic     hit, hit_way, hit_dirty;

  assign snp = dcachef_t'(cc.ccsnoopaddr);

  snoop_tag_match u_match (
    .valid_i     (frame_valid),
    .dirty_i     (frame_dirty),
    .tag_i       (frame_tag),
    .snp_tag_i   (snp.tag),
    .hit_o       (hit),
    .hit_way_o   (hit_way),
    .hit_dirty_o (hit_dirty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      blk_q   <= '0;
      way_q   <= 1'b0;
      hit_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          inv_q <= 1'b0;
          if (cc.ccwait) begin
            blk_q   <= cc.ccsnoopaddr[31:3];
            way_q   <= hit_way;
            hit_q   <= hit;
            state_q <= (hit && hit_dirty) ? SEND0 : CLEAN;
          end
        end
        CLEAN: state_q <= IDLE;
        SEND0: begin
          if (cc.ccinv) inv_q <= 1'b1;
          // Controller dropping ccwait abandons the transfer untouched.
          if (!cc.ccwait)     state_q <= IDLE;
          else if (!cc.dwait) state_q <= SEND1;
        end
        SEND1: begin
          if (cc.ccinv) inv_q <= 1'b1;
          if (!cc.dwait || !cc.ccwait) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    frame_index      = snp.idx;
    frame_we         = 1'b0;
    frame_way        = 1'b0;
    frame_valid_next = 1'b0;
    frame_dirty_next = 1'b0;
    cc.ccwrite       = 1'b0;
    cc.dstore        = '0;
    cc.daddr         = '0;
    if (state_q != IDLE) frame_index = blk_q[2:0];
    unique case (state_q)
      CLEAN: begin
        if (cc.ccinv && hit_q) begin
          frame_we  = 1'b1;
          frame_way = way_q;
        end
      end
      SEND0: begin
        cc.ccwrite = 1'b1;
        cc.dstore  = frame_word0[way_q];
        cc.daddr   = {blk_q, 3'b000};
      end
      SEND1: begin
        cc.ccwrite = 1'b1;
        cc.dstore  = frame_word1[way_q];
        cc.daddr   = {blk_q, 3'b100};
        if (!cc.dwait) begin
          frame_we         = 1'b1;
          frame_way        = way_q;
          frame_valid_next = !(inv_q || cc.ccinv);
        end
      end
      default: ;
    endcase
  end

  assign cc.snoop_busy = cc.ccwait || (state_q != IDLE);
endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Scoreboard bench for dcache_snoop_responder with a frame-array model.
// Stimulus pushes expected beats/updates; a monitor pops and compares.
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dcache_snoop_responder_if ifc ();

  logic [1:0]            fv, fd;
  logic [1:0][TAG_W-1:0] ft;
  logic [1:0][31:0]      fw0, fw1;
  logic [2:0]            fidx;
  logic                  fwe, fway, fvn, fdn;

  dcache_snoop_responder dut (
    .CLK              (CLK),
    .RST              (RST),
    .cc               (ifc.slave),
    .frame_valid      (fv),
    .frame_dirty      (fd),
    .frame_tag        (ft),
    .frame_word0      (fw0),
    .frame_word1      (fw1),
    .frame_index      (fidx),
    .frame_we         (fwe),
    .frame_way        (fway),
    .frame_valid_next (fvn),
    .frame_dirty_next (fdn)
  );

  logic        m_v [8][2];
  logic        m_d [8][2];
  logic [25:0] m_t [8][2];
  logic [31:0] m_w0[8][2];
  logic [31:0] m_w1[8][2];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      fv[w]  = m_v[fidx][w];
      fd[w]  = m_d[fidx][w];
      ft[w]  = m_t[fidx][w];
      fw0[w] = m_w0[fidx][w];
      fw1[w] = m_w1[fidx][w];
    end
  end

  always @(posedge CLK) begin
    if (fwe) begin
      m_v[fidx][fway] <= fvn;
      m_d[fidx][fway] <= fdn;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } beat_t;
  typedef struct {
    logic [2:0] idx;
    logic       way;
    logic       v;
    logic       dt;
  } upd_t;

  beat_t bq[$];
  upd_t  uq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (ifc.ccwrite && !ifc.dwait) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", ifc.dstore, 32'hx);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("beat_data", ifc.dstore, b.d);
          chk("beat_addr", ifc.daddr, b.a);
        end
      end
      if (fwe) begin
        if (uq.size() == 0) begin
          chk("we_unexpected", {31'd0, fwe}, 32'd0);
        end else begin
          upd_t u;
          u = uq.pop_front();
          chk("upd_idx", {29'd0, fidx}, {29'd0, u.idx});
          chk("upd_way", {31'd0, fway}, {31'd0, u.way});
          chk("upd_valid", {31'd0, fvn}, {31'd0, u.v});
          chk("upd_dirty", {31'd0, fdn}, {31'd0, u.dt});
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic inv, input logic dw,
                     input logic [31:0] a);
    @(posedge CLK);
    #1;
    ifc.ccwait = w;
    ifc.ccinv = inv;
    ifc.dwait = dw;
    ifc.ccsnoopaddr = a;
    @(negedge CLK);
  endtask

  task automatic push_beats();
    bq.push_back('{32'hAAAA0001, 32'h0000_1048});
    bq.push_back('{32'hAAAA0002, 32'h0000_104C});
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
        m_t[s][w] = '0;
        m_w0[s][w] = 32'h0;
        m_w1[s][w] = 32'h0;
      end
    end
    ifc.ccwait = 1'b0;
    ifc.ccinv = 1'b0;
    ifc.dwait = 1'b1;
    ifc.ccsnoopaddr = 32'h0;
    // addr 0x1048 -> set 1, tag 0x41, dirty in way 1
    m_v[1][0] = 1'b1; m_t[1][0] = 26'h99;
    m_v[1][1] = 1'b1; m_d[1][1] = 1'b1; m_t[1][1] = 26'h41;
    m_w0[1][1] = 32'hAAAA0001; m_w1[1][1] = 32'hAAAA0002;

    repeat (2) @(negedge CLK);
    chk("rst_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);
    chk("rst_dstore", ifc.dstore, 32'd0);
    chk("rst_busy", {31'd0, ifc.snoop_busy}, 32'd0);
    chk("rst_we", {31'd0, fwe}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // read snoop, dirty hit
    push_beats();
    uq.push_back('{3'd1, 1'b1, 1'b1, 1'b0});
    cyc(1, 0, 1, 32'h1048);
    chk("t1_c1_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);
    chk("t1_c1_busy", {31'd0, ifc.snoop_busy}, 32'd1);
    cyc(1, 0, 0, 32'h1048);
    chk("t1_c2_ccwrite", {31'd0, ifc.ccwrite}, 32'd1);
    cyc(1, 0, 0, 32'h0);
    chk("t1_c3_ccwrite", {31'd0, ifc.ccwrite}, 32'd1);
    chk("t1_c3_index", {29'd0, fidx}, 32'd1);
    cyc(0, 0, 1, 32'h0);
    chk("t1_idle_busy", {31'd0, ifc.snoop_busy}, 32'd0);
    chk("t1_idle_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);

    // write-miss snoop: ccinv in SEND1
    m_d[1][1] = 1'b1;
    push_beats();
    uq.push_back('{3'd1, 1'b1, 1'b0, 1'b0});
    cyc(1, 0, 1, 32'h1048);
    cyc(1, 0, 0, 32'h1048);
    cyc(1, 1, 0, 32'h1048);
    cyc(0, 0, 1, 32'h0);

    // invalidate clean hit at 0x2000 (set 0, tag 0x80, way 0)
    m_v[0][0] = 1'b1; m_d[0][0] = 1'b0; m_t[0][0] = 26'h80;
    uq.push_back('{3'd0, 1'b0, 1'b0, 1'b0});
    cyc(1, 0, 1, 32'h2000);
    cyc(0, 1, 1, 32'h2000);
    chk("t3_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);
    chk("t3_we", {31'd0, fwe}, 32'd1);
    cyc(0, 0, 1, 32'h0);
    chk("t3_model_valid", {31'd0, m_v[0][0]}, 32'd0);

    // miss at 0x3000
    cyc(1, 0, 1, 32'h3000);
    cyc(0, 1, 1, 32'h3000);
    chk("t4_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);
    chk("t4_we", {31'd0, fwe}, 32'd0);
    chk("t4_busy", {31'd0, ifc.snoop_busy}, 32'd1);
    cyc(0, 0, 1, 32'h0);
    chk("t4_idle_busy", {31'd0, ifc.snoop_busy}, 32'd0);

    // dwait stall in SEND0
    m_v[1][1] = 1'b1; m_d[1][1] = 1'b1;
    push_beats();
    uq.push_back('{3'd1, 1'b1, 1'b1, 1'b0});
    cyc(1, 0, 1, 32'h1048);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 32'h1048);
      chk("t5_stall_ccwrite", {31'd0, ifc.ccwrite}, 32'd1);
      chk("t5_stall_dstore", ifc.dstore, 32'hAAAA0001);
      chk("t5_stall_daddr", ifc.daddr, 32'h1048);
    end
    cyc(1, 0, 0, 32'h1048);
    chk("t5_send0_dstore", ifc.dstore, 32'hAAAA0001);
    cyc(1, 0, 0, 32'h1048);
    chk("t5_send1_dstore", ifc.dstore, 32'hAAAA0002);
    cyc(0, 0, 1, 32'h0);

    // reset in SEND1
    m_d[1][1] = 1'b1;
    bq.push_back('{32'hAAAA0001, 32'h0000_1048});
    cyc(1, 0, 1, 32'h1048);
    cyc(1, 0, 0, 32'h1048);
    cyc(1, 0, 1, 32'h1048);
    chk("t6_send1_daddr", ifc.daddr, 32'h104C);
    #1 RST = 1'b1;
    #1;
    chk("t6_rst_ccwrite", {31'd0, ifc.ccwrite}, 32'd0);
    chk("t6_rst_dstore", ifc.dstore, 32'd0);
    chk("t6_rst_daddr", ifc.daddr, 32'd0);
    chk("t6_rst_we", {31'd0, fwe}, 32'd0);
    cyc(0, 0, 1, 32'h0);
    chk("t6_rst_busy", {31'd0, ifc.snoop_busy}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    cyc(0, 0, 1, 32'h0);
    chk("t6_post_busy", {31'd0, ifc.snoop_busy}, 32'd0);
    chk("t6_dirty_kept", {31'd0, m_d[1][1]}, 32'd1);

    chk("beats_left", bq.size(), 32'd0);
    chk("upds_left", uq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dcache_snoop_responder.md
# dcache_snoop_responder

Snoop-side responder inside each L1 data cache for the two-CPU MSI coherence scheme. Answers the coherence controller's snoop handshake (ccwait, ccsnoopaddr, ccinv, dwait): looks up the snooped block in the 2-way, 8-set dcache frame array, reports a dirty hit on ccwrite, and streams both block words back over dstore/daddr. It then downgrades M to S, or invalidates on ccinv. It stalls the cache's own processor-side FSM while a snoop is in progress.

## Interface
- WAYS, 2, associativity; fixed, other values unsupported
- SETS, 8, sets; index = addr[5:3], tag = addr[31:6], block offset = addr[2]
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ccwait  in  1  snoop request from controller
- ccinv  in  1  invalidate snooped block
- ccsnoopaddr  in  32  snooped word address
- dwait  in  1  low = current word accepted by controller/RAM
- frame_valid, frame_dirty  in  2 each  per-way bits of set frame_index
- frame_tag  in  2x26  per-way tags of set frame_index
- frame_word0, frame_word1  in  2x32  per-way block words of set frame_index
- frame_index  out  3  set being inspected
- frame_we  out  1  one-cycle frame-state update strobe
- frame_way  out  1  way to update
- frame_valid_next, frame_dirty_next  out  1 each  new bits written on frame_we
- ccwrite  out  1  snoop hit on dirty (M) block
- dstore  out  32  word supplied to controller
- daddr  out  32  address of dstore word
- snoop_busy  out  1  cache FSM must not access the frame array while high

## Operation
- States: IDLE, CLEAN, SEND0, SEND1.
- IDLE:
  - frame_index = ccsnoopaddr[5:3], combinationally.
  - On ccwait=1, latch addr, hit, hit_way, hit_dirty.
  - Hit means valid and tag equal in a way. At most one way matches. If both match, way 0 wins.
  - Next state is SEND0 if hit and dirty, else CLEAN.
- CLEAN (one cycle):
  - ccwrite=0.
  - If ccinv=1 and hit: frame_we=1 on hit_way, valid_next=0, dirty_next=0.
  - Next state is IDLE unconditionally.
- SEND0:
  - ccwrite=1, dstore=frame_word0[hit_way], daddr={addr[31:3],3'b000}.
  - ccinv=1 in any SEND cycle sets inv_seen.
  - dwait=0 moves to SEND1.
  - ccwait=0 aborts to IDLE with no frame update.
- SEND1:
  - ccwrite=1, dstore=frame_word1[hit_way], daddr={addr[31:3],3'b100}.
  - When dwait=0: frame_we=1, dirty_next=0, valid_next=!(inv_seen|ccinv), then go to IDLE.
  - ccwait=0 with dwait=1 aborts to IDLE with no update.
- frame_index = latched addr[5:3] in all non-IDLE states.
- snoop_busy = ccwait | (state!=IDLE).
- dstore/daddr = 0 and ccwrite = 0 outside SEND states.

## Timing
- Reset value of every output and register is 0; state = IDLE; inv_seen = 0. RST mid-snoop returns to IDLE with no frame_we.
- Lookup latency:
  - ccwrite is valid the cycle after ccwait first rises.
  - This matches the controller's LOAD_0 / WRITE_MISS_CLEAN_0 sampling of snoop_hit.
- Dirty hit: SEND0 and SEND1 each hold ≥1 cycle, extended by dwait=1. Minimum snoop is 3 cycles including the IDLE request cycle.
- Clean or miss: 2 cycles (IDLE request, CLEAN).
- frame_we is a single-cycle pulse; the frame array commits it on the next edge.
- ccinv with ccwait=0 while in IDLE is ignored; the controller always precedes it with ccwait.
- ccwait held high in the cycle that returns to IDLE starts a new snoop, back-to-back with no bubble.

## Structure
- Shared package cpu_types_pkg:
  - dcache address-field typedef (tag/idx/blkoff/bytoff widths 26/3/1/2).
  - New snoop_state_t enum {IDLE, CLEAN, SEND0, SEND1}.
- Sub-module snoop_tag_match: combinational 2-way tag compare giving hit, hit_way, hit_dirty. This isolates the way priority rule.

## Test plan
- Read snoop, dirty hit:
  - Stimulus: way1 tag for addr 0x00001048, dirty, words 0xAAAA0001/0xAAAA0002; ccwait 3 cycles, dwait low in cycles 2 and 3.
  - Response: ccwrite=1 in cycles 2–3; dstore/daddr 0xAAAA0001@0x1048 then 0xAAAA0002@0x104C; frame_we on way1 with valid=1, dirty=0.
- Write-miss snoop, dirty hit:
  - Stimulus: same setup, ccinv=1 during SEND1.
  - Response: frame_we with valid_next=0, dirty_next=0.
- Invalidate clean hit:
  - Stimulus: valid clean way0 at 0x2000; ccwait 1 cycle, then ccinv=1.
  - Response: ccwrite=0; frame_we way0, valid_next=0.
- Miss:
  - Stimulus: ccwait with a tag absent from both ways, then ccinv=1.
  - Response: ccwrite=0, frame_we never asserted, back in IDLE after 2 cycles.
- dwait stall:
  - Stimulus: dwait=1 for 4 cycles in SEND0.
  - Response: dstore held at word0 and ccwrite=1 throughout; SEND1 is entered only on dwait=0.
- Reset mid-snoop:
  - Stimulus: RST asserted in SEND1.
  - Response: all outputs 0 immediately, no frame_we, snoop_busy=0 once ccwait=0.
